// File: rtl/cpu_pkg.sv
// Shared CPU definitions: default datapath widths, forwarding-source indices
// and the store-size encoding used by the store path.
package cpu_pkg;

    localparam int unsigned CPU_DATA_W = 16;
    localparam int unsigned CPU_ADDR_W = 16;

    localparam int unsigned SRC_RF    = 0;
    localparam int unsigned SRC_EXMEM = 1;
    localparam int unsigned SRC_MEMWB = 2;
    localparam int unsigned SRC_LOAD  = 3;

    typedef enum logic {
        ST_WORD = 1'b0,
        ST_BYTE = 1'b1
    } st_size_e;

endpackage

// File: rtl/store_align.sv
// Combinational store-data path: forwarding-source select, byte replication
// for byte stores and byte-enable generation.
module store_align
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned NSRC   = 4,
    parameter int unsigned SEL_W  = $clog2(NSRC),
    parameter int unsigned LANE_W = $clog2(DATA_W / 8)
) (
    input  logic [NSRC*DATA_W-1:0] src_data_i,
    input  logic [SEL_W-1:0]       src_sel_i,
    input  st_size_e               size_i,
    input  logic [LANE_W-1:0]      lane_i,
    output logic [DATA_W-1:0]      wdata_c,
    output logic [DATA_W/8-1:0]    be_c,
    output logic                   sel_bad_c
);

    localparam int unsigned LANES = DATA_W / 8;

    logic [DATA_W-1:0] sel_data;
    logic              sel_hit;

    // An out-of-range select matches no source and leaves the data at zero.
    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int unsigned i = 0; i < NSRC; i++) begin
            if (src_sel_i == SEL_W'(i)) begin
                sel_data = src_data_i[i*DATA_W +: DATA_W];
                sel_hit  = 1'b1;
            end
        end
    end

    always_comb begin
        sel_bad_c = !sel_hit;
        if (size_i == ST_BYTE) begin
            wdata_c = {LANES{sel_data[7:0]}};
            be_c    = LANES'(1) << lane_i;
        end else begin
            wdata_c = sel_data;
            be_c    = '1;
        end
        if (!sel_hit) begin
            be_c = '0;
        end
    end

endmodule

// File: rtl/dmem_wdata_stage.sv
// Registered data-memory write-data stage: aligned store data presented to
// memory through a 2-entry (main + skid) valid/ready buffer with flush.
module dmem_wdata_stage
    import cpu_pkg::*;
#(
    parameter int unsigned DATA_W = CPU_DATA_W,
    parameter int unsigned ADDR_W = CPU_ADDR_W,
    parameter int unsigned NSRC   = 4,
    parameter int unsigned SEL_W  = $clog2(NSRC)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NSRC*DATA_W-1:0] src_data,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic                   st_byte,
    input  logic [ADDR_W-1:0]      st_addr,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDR_W-1:0]      out_addr,
    output logic [DATA_W-1:0]      out_wdata,
    output logic [DATA_W/8-1:0]    out_be,
    output logic                   sel_err
);

    localparam int unsigned BE_W   = DATA_W / 8;
    localparam int unsigned LANE_W = $clog2(BE_W);

    logic [DATA_W-1:0] new_wdata;
    logic [BE_W-1:0]   new_be;
    logic              new_bad;
    logic              accept;
    logic              issue;

    logic [1:0]        count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              sel_err_q, sel_err_d;
    logic [DATA_W-1:0] main_wdata_q, main_wdata_d, skid_wdata_q, skid_wdata_d;
    logic [BE_W-1:0]   main_be_q, main_be_d, skid_be_q, skid_be_d;
    logic [ADDR_W-1:0] main_addr_q, main_addr_d, skid_addr_q, skid_addr_d;

    store_align #(
        .DATA_W (DATA_W),
        .NSRC   (NSRC),
        .SEL_W  (SEL_W),
        .LANE_W (LANE_W)
    ) u_align (
        .src_data_i (src_data),
        .src_sel_i  (src_sel),
        .size_i     (st_size_e'(st_byte)),
        .lane_i     (st_addr[LANE_W-1:0]),
        .wdata_c    (new_wdata),
        .be_c       (new_be),
        .sel_bad_c  (new_bad)
    );

    assign accept = in_valid && in_ready_q;
    assign issue  = out_valid_q && out_ready;

    // Main is always the head; skid only fills when main is held by backpressure.
    always_comb begin
        count_d      = count_q;
        main_wdata_d = main_wdata_q;
        main_be_d    = main_be_q;
        main_addr_d  = main_addr_q;
        skid_wdata_d = skid_wdata_q;
        skid_be_d    = skid_be_q;
        skid_addr_d  = skid_addr_q;

        if (flush) begin
            count_d = 2'd0;
        end else if (accept && (count_q == 2'd0 || issue)) begin
            main_wdata_d = new_wdata;
            main_be_d    = new_be;
            main_addr_d  = st_addr;
            count_d      = 2'd1;
        end else if (accept) begin
            skid_wdata_d = new_wdata;
            skid_be_d    = new_be;
            skid_addr_d  = st_addr;
            count_d      = 2'd2;
        end else if (issue) begin
            if (count_q == 2'd2) begin
                main_wdata_d = skid_wdata_q;
                main_be_d    = skid_be_q;
                main_addr_d  = skid_addr_q;
            end
            count_d = count_q - 2'd1;
        end

        in_ready_d  = (count_d != 2'd2);
        out_valid_d = (count_d != 2'd0);
        sel_err_d   = accept && new_bad && !flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q      <= 2'd0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            sel_err_q    <= 1'b0;
            main_wdata_q <= '0;
            main_be_q    <= '0;
            main_addr_q  <= '0;
            skid_wdata_q <= '0;
            skid_be_q    <= '0;
            skid_addr_q  <= '0;
        end else begin
            count_q      <= count_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            sel_err_q    <= sel_err_d;
            main_wdata_q <= main_wdata_d;
            main_be_q    <= main_be_d;
            main_addr_q  <= main_addr_d;
            skid_wdata_q <= skid_wdata_d;
            skid_be_q    <= skid_be_d;
            skid_addr_q  <= skid_addr_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sel_err   = sel_err_q;
    assign out_wdata = main_wdata_q;
    assign out_be    = main_be_q;
    assign out_addr  = main_addr_q;

endmodule

// File: doc/dmem_wdata_stage.md
Name: dmem_wdata_stage

Overview:
- Parametrised, registered successor to the data-memory write-data select path.
- Picks store data from one of NSRC forwarding sources: register file, EX/MEM result, MEM/WB result, load-return data.
- Byte-aligns the chosen data and generates byte enables.
- Presents the result to data memory through a 2-entry skid buffer with valid/ready handshake. Sits between the EX/MEM pipeline register and the data memory write port.

Parameters:
- DATA_W, 16: store data width; multiple of 8, at least 16.
- ADDR_W, 16: store address width.
- NSRC, 4: number of forwarding sources, at least 2.
- SEL_W, $clog2(NSRC): width of the source select.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream store request valid
- in_ready  out  1  stage can accept a request
- src_data  in  NSRC*DATA_W  packed sources; source i occupies bits [i*DATA_W +: DATA_W]
- src_sel  in  SEL_W  forwarding select from the hazard unit
- st_byte  in  1  1 = byte store, 0 = full-word store
- st_addr  in  ADDR_W  store address
- flush  in  1  discard all buffered requests (branch/exception)
- out_valid  out  1  request valid to data memory
- out_ready  in  1  data memory accepts
- out_addr  out  ADDR_W  store address, passed through unchanged
- out_wdata  out  DATA_W  aligned write data
- out_be  out  DATA_W/8  byte enables
- sel_err  out  1  one-cycle pulse: an accepted request had src_sel >= NSRC

Behaviour:
- Reset: rst_n low forces asynchronously, regardless of clk:
  - buffer empty, out_valid=0, in_ready=1, sel_err=0
  - out_wdata, out_be, out_addr = 0
- Handshakes:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - Issue occurs when out_valid && out_ready.
- Selection:
  - sel_data = src_data slice src_sel.
  - If src_sel >= NSRC: sel_data = 0, out_be forced to 0 (the write is suppressed), and sel_err pulses the cycle after accept.
- Alignment:
  - Full-word store: wdata = sel_data, be = all ones. Low address bits are ignored; the caller guarantees alignment.
  - Byte store: lane k = log2(DATA_W/8) low bits of st_addr. wdata = sel_data[7:0] replicated into every lane. be = one-hot bit k.
- Latency: 1 cycle. Data accepted at edge N appears on outputs after edge N; out_valid is high in cycle N+1.
- Buffer: 2 entries (main + skid), FIFO order.
  - in_ready = registered "count < 2". It depends only on state, never combinationally on out_ready.
  - Outputs always come from the head entry.
- Simultaneous accept and issue:
  - count 1: count stays 1, new entry becomes head.
  - count 2: in_ready is 0, so no accept; only the issue happens.
- Full (count 2):
  - in_ready = 0.
  - in_valid is ignored; upstream holds its request.
- Empty: out_valid = 0; out_wdata, out_be, out_addr hold their last values.
- Flush:
  - Synchronous; count goes to 0 at the next edge.
  - A simultaneous accept is dropped and a simultaneous issue still completes at the memory.
  - in_ready = 1 in the following cycle.
  - Flush takes priority over everything except reset.
- Reset mid-operation: all entries are lost immediately; no partial write is signalled.
- Handshake stability: while out_valid && !out_ready, out_wdata, out_be and out_addr are stable.

Decomposition:
- Shared package cpu_pkg:
  - DATA_W and ADDR_W defaults.
  - Source index constants: SRC_RF=0, SRC_EXMEM=1, SRC_MEMWB=2, SRC_LOAD=3.
  - Store size enum.
- Natural sub-module: store_align (combinational select + byte replication + byte-enable generation).
- The top level holds the skid-buffer control and storage.

Test Plan:
- Reset and basic word store: drive rst_n=0 then 1. Accept sel=1, src1=16'hBEEF, st_byte=0, addr=16'h0040 -> next cycle out_valid=1, out_wdata=BEEF, out_be=2'b11, out_addr=0040. Issue with out_ready=1 -> out_valid=0.
- Byte store lanes: sel=2, src2=16'h12A5. addr=16'h0003 -> out_wdata=A5A5, out_be=2'b10. addr=16'h0002 -> out_be=2'b01.
- Backpressure/full:
  - Hold out_ready=0 and drive 3 back-to-back requests with data 1,2,3 -> in_ready drops after the 2nd accept; the 3rd is held.
  - Release out_ready -> outputs 1,2,3 appear in order with no loss or duplication.
- Simultaneous accept and issue at count 1: stream 10 requests with out_ready=1 -> 1 request per cycle, in_ready stays 1.
- Flush: count=2, assert flush for one cycle with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed data never appears.
- Bad select and async reset:
  - NSRC=3 build, src_sel=3 -> out_be=0, out_wdata=0, and sel_err pulses for exactly 1 cycle.
  - Drop rst_n between clock edges with count=2 -> out_valid=0 immediately.
